// File: rtl/fft_sym_sched.sv
// LTE symbol/slot scheduler: counts baseband samples into symbols, slots and frames
// and emits the header / first-symbol strobes consumed by the CP-removal preprocessor.
module fft_sym_sched #(
    parameter int DATA_NBIT       = 15,
    parameter int SLOTS_PER_FRAME = 20,
    parameter int CNT_NBIT        = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        frame_sync,
    input  logic                        cfg_fft_type,
    input  logic                        cfg_cp_type,
    input  logic [1:0]                  cfg_num_pat,
    input  logic signed [DATA_NBIT-1:0] in_i,
    input  logic signed [DATA_NBIT-1:0] in_q,
    input  logic                        in_v,
    output logic signed [DATA_NBIT-1:0] out_i,
    output logic signed [DATA_NBIT-1:0] out_q,
    output logic                        out_v,
    output logic                        out_h,
    output logic                        out_s,
    output logic                        out_fft_type,
    output logic                        out_cp_type,
    output logic [1:0]                  out_num_pat,
    output logic [2:0]                  sym_idx,
    output logic [4:0]                  slot_idx,
    output logic                        running,
    output logic                        sync_err,
    output logic                        rate_err,
    input  logic                        err_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_RUN} state_t;

    state_t                      state_q, state_d;
    logic [CNT_NBIT-1:0]         cnt_q, cnt_d, len_m1;
    logic [2:0]                  sym_q, sym_d, sym_last;
    logic [4:0]                  slot_q, slot_d;
    logic                        fft_q, fft_d, cp_q, cp_d;
    logic [1:0]                  pat_q, pat_d;
    logic                        prev_v_q, prev_v_d;
    logic                        sync_err_q, sync_err_d, rate_err_q, rate_err_d;
    logic                        sync_set, rate_set, latch_cfg, at_frame_start;
    logic                        v_p1_q, v_p1_d, h_p1_q, h_p1_d, s_p1_q, s_p1_d;
    logic                        v_p2_q, v_p2_d;
    logic signed [DATA_NBIT-1:0] i_p1_q, i_p1_d, q_p1_q, q_p1_d;
    logic signed [DATA_NBIT-1:0] i_p2_q, i_p2_d, q_p2_q, q_p2_d;

    // Symbol length minus one: N = 2048 - 512*num_pat plus the cyclic prefix.
    function automatic logic [CNT_NBIT-1:0] sym_len_m1(input logic fft, input logic cp,
                                                       input logic [1:0] pat,
                                                       input logic [2:0] sym);
        logic [CNT_NBIT-1:0] n;
        logic [CNT_NBIT-1:0] cp_len;
        n = CNT_NBIT'({3'd4 - {1'b0, pat}, 9'd0});
        if (fft)
            cp_len = '0;
        else if (cp)
            cp_len = CNT_NBIT'(512);
        else if (sym == 3'd0)
            cp_len = CNT_NBIT'(160);
        else
            cp_len = CNT_NBIT'(144);
        return n + cp_len - CNT_NBIT'(1);
    endfunction

    always_comb begin
        len_m1         = sym_len_m1(fft_q, cp_q, pat_q, sym_q);
        sym_last       = cp_q ? 3'd5 : 3'd6;
        at_frame_start = (cnt_q == '0) && (sym_q == 3'd0) && (slot_q == 5'd0);

        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_d      = sym_q;
        slot_d     = slot_q;
        fft_d      = fft_q;
        cp_d       = cp_q;
        pat_d      = pat_q;
        latch_cfg  = 1'b0;
        sync_set   = 1'b0;
        rate_set   = in_v & prev_v_q;
        prev_v_d   = in_v;
        v_p1_d     = 1'b0;
        h_p1_d     = 1'b0;
        s_p1_d     = 1'b0;
        i_p1_d     = in_i;
        q_p1_d     = in_q;
        v_p2_d     = v_p1_q;
        i_p2_d     = i_p1_q;
        q_p2_d     = q_p1_q;

        case (state_q)
            ST_IDLE: begin
                if (en)
                    state_d = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (in_v && frame_sync) begin
                    state_d   = ST_RUN;
                    latch_cfg = 1'b1;
                    cnt_d     = CNT_NBIT'(1);
                    sym_d     = 3'd0;
                    slot_d    = 5'd0;
                    v_p1_d    = 1'b1;
                    h_p1_d    = 1'b1;
                    s_p1_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_v) begin
                    v_p1_d = 1'b1;
                    if (frame_sync && !at_frame_start) begin
                        // Resync: this sample becomes sample 0 of slot 0 symbol 0.
                        sync_set  = 1'b1;
                        latch_cfg = 1'b1;
                        cnt_d     = CNT_NBIT'(1);
                        sym_d     = 3'd0;
                        slot_d    = 5'd0;
                        h_p1_d    = 1'b1;
                        s_p1_d    = 1'b1;
                    end else begin
                        h_p1_d = (cnt_q == '0);
                        s_p1_d = (cnt_q == '0) && (sym_q == 3'd0);
                        if (cnt_q == len_m1) begin
                            cnt_d = '0;
                            if (sym_q == sym_last) begin
                                sym_d = 3'd0;
                                if (slot_q == 5'(SLOTS_PER_FRAME - 1)) begin
                                    slot_d = 5'd0;
                                    if (en)
                                        latch_cfg = 1'b1;
                                    else
                                        state_d = ST_IDLE;
                                end else begin
                                    slot_d = slot_q + 5'd1;
                                end
                            end else begin
                                sym_d = sym_q + 3'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_NBIT'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (latch_cfg) begin
            fft_d = cfg_fft_type;
            cp_d  = cfg_cp_type;
            pat_d = cfg_num_pat;
        end

        // A fresh error in the same cycle outranks err_clr.
        if (sync_set)
            sync_err_d = 1'b1;
        else if (err_clr)
            sync_err_d = 1'b0;
        else
            sync_err_d = sync_err_q;

        if (rate_set)
            rate_err_d = 1'b1;
        else if (err_clr)
            rate_err_d = 1'b0;
        else
            rate_err_d = rate_err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sym_q      <= 3'd0;
            slot_q     <= 5'd0;
            fft_q      <= 1'b0;
            cp_q       <= 1'b0;
            pat_q      <= 2'd0;
            prev_v_q   <= 1'b0;
            sync_err_q <= 1'b0;
            rate_err_q <= 1'b0;
            v_p1_q     <= 1'b0;
            h_p1_q     <= 1'b0;
            s_p1_q     <= 1'b0;
            v_p2_q     <= 1'b0;
            i_p1_q     <= '0;
            q_p1_q     <= '0;
            i_p2_q     <= '0;
            q_p2_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_q      <= sym_d;
            slot_q     <= slot_d;
            fft_q      <= fft_d;
            cp_q       <= cp_d;
            pat_q      <= pat_d;
            prev_v_q   <= prev_v_d;
            sync_err_q <= sync_err_d;
            rate_err_q <= rate_err_d;
            // stage p1: header strobes lead their sample by one cycle
            v_p1_q     <= v_p1_d;
            h_p1_q     <= h_p1_d;
            s_p1_q     <= s_p1_d;
            i_p1_q     <= i_p1_d;
            q_p1_q     <= q_p1_d;
            // stage p2: sample presented to the preprocessor
            v_p2_q     <= v_p2_d;
            i_p2_q     <= i_p2_d;
            q_p2_q     <= q_p2_d;
        end
    end

    assign out_i        = i_p2_q;
    assign out_q        = q_p2_q;
    assign out_v        = v_p2_q;
    assign out_h        = h_p1_q;
    assign out_s        = s_p1_q;
    assign out_fft_type = fft_q;
    assign out_cp_type  = cp_q;
    assign out_num_pat  = pat_q;
    assign sym_idx      = sym_q;
    assign slot_idx     = slot_q;
    assign running      = (state_q == ST_RUN);
    assign sync_err     = sync_err_q;
    assign rate_err     = rate_err_q;

endmodule
